// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute control FSM for the 8-bit datapath.
// Drives the IR load controls, PC controls, memory req strobes (req/ready
// handshake with optional timeout) and the ALU select. HLT parks the machine
// until reset.
// Optional feature: define ILLEGAL_TRAP_EN to trap undefined opcodes
// (TRAP clears the IR, then HALT with illegal held high). Without it,
// undefined opcodes behave as NOP and illegal is tied low.
module control_sequencer #(
  parameter int OPW    = 5,
  parameter int ALUW   = 3,
  parameter int MEM_TO = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            flag_z,
  input  logic            flag_c,
  input  logic            mem_ready,
  output logic            ir_ena,
  output logic            ir_sel,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            addr_sel,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            acc_we,
  output logic [ALUW-1:0] alu_op,
  output logic            halted,
  output logic            illegal
);

  localparam int WW = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_STA = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4);
  localparam logic [OPW-1:0] OP_AND = OPW'(5);
  localparam logic [OPW-1:0] OP_OR  = OPW'(6);
  localparam logic [OPW-1:0] OP_NOT = OPW'(7);
  localparam logic [OPW-1:0] OP_JMP = OPW'(8);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(9);
  localparam logic [OPW-1:0] OP_JC  = OPW'(10);
  localparam logic [OPW-1:0] OP_HLT = '1;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_LOAD,
    S_DECODE,
    S_EXEC,
    S_MEMRD,
    S_MEMWR,
    S_JUMP,
    S_HALT
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [ALUW-1:0] alu_q, alu_d;
  logic            timeout;
`ifdef ILLEGAL_TRAP_EN
  logic            ill_q, ill_d;
`endif

  // Timeout fires on the MEM_TO-th consecutive wait cycle; MEM_TO=0 never fires.
  assign timeout = (MEM_TO != 0) && (wait_q == WW'(MEM_TO - 1));

  // State, wait counter and latched ALU select registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      wait_q  <= '0;
      alu_q   <= '0;
`ifdef ILLEGAL_TRAP_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      alu_q   <= alu_d;
`ifdef ILLEGAL_TRAP_EN
      ill_q   <= ill_d;
`endif
    end
  end

  // Next-state logic; the wait counter only survives a cycle that stays in a
  // waiting state, so any state change clears it.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    alu_d   = alu_q;
`ifdef ILLEGAL_TRAP_EN
    ill_d   = ill_q;
`endif
    case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready)    state_d = (state_q == S_FETCH) ? S_LOAD : S_FETCH;
        else if (timeout) state_d = S_HALT;
        else              wait_d  = wait_q + WW'(1);
      end
      S_LOAD:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOP: state_d = S_FETCH;
          OP_ADD: begin state_d = S_EXEC; alu_d = ALUW'(1); end
          OP_SUB: begin state_d = S_EXEC; alu_d = ALUW'(2); end
          OP_AND: begin state_d = S_EXEC; alu_d = ALUW'(3); end
          OP_OR:  begin state_d = S_EXEC; alu_d = ALUW'(4); end
          OP_NOT: begin state_d = S_EXEC; alu_d = ALUW'(5); end
          OP_LDA: state_d = S_MEMRD;
          OP_STA: state_d = S_MEMWR;
          OP_JMP: state_d = S_JUMP;
          OP_JZ:  state_d = flag_z ? S_JUMP : S_FETCH;
          OP_JC:  state_d = flag_c ? S_JUMP : S_FETCH;
          OP_HLT: state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
          default: begin state_d = S_TRAP; ill_d = 1'b1; end
`else
          default: state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC:  state_d = S_FETCH;
      S_JUMP:  state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:  state_d = S_HALT;
`endif
      default: state_d = S_INIT;
    endcase
  end

  // Output decode; gating with rst makes every output drop asynchronously in reset.
  always_comb begin
    ir_ena   = 1'b0;
    ir_sel   = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    addr_sel = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    acc_we   = 1'b0;
    alu_op   = '0;
    halted   = 1'b0;
    illegal  = 1'b0;
    if (rst) begin
      case (state_q)
        S_INIT:  begin ir_ena = 1'b1; ir_sel = 1'b1; end
        S_FETCH: mem_rd = 1'b1;
        S_LOAD:  begin ir_ena = 1'b1; pc_inc = 1'b1; end
        S_EXEC:  begin acc_we = 1'b1; alu_op = alu_q; end
        S_MEMRD: begin mem_rd = 1'b1; addr_sel = 1'b1; acc_we = mem_ready; end
        S_MEMWR: begin mem_wr = 1'b1; addr_sel = 1'b1; end
        S_JUMP:  pc_load = 1'b1;
        S_HALT: begin
          halted = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          illegal = ill_q;
`endif
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:  begin ir_ena = 1'b1; ir_sel = 1'b1; illegal = 1'b1; end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each scenario queues per-cycle
// stimulus together with the expected output vector, then drains the queue
// one clock at a time comparing the DUT outputs at the falling edge.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic       flag_z, flag_c, mem_ready;
  logic       ir_ena, ir_sel, pc_inc, pc_load, addr_sel;
  logic       mem_rd, mem_wr, acc_we, halted, illegal;
  logic [2:0] alu_op;
  logic [12:0] obs;

  int n_cmp  = 0;
  int n_fail = 0;

  // {ir_ena, ir_sel, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_we, alu_op, halted, illegal}
  assign obs = {ir_ena, ir_sel, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, acc_we,
                alu_op, halted, illegal};

  localparam logic [12:0] V_ZERO  = 13'h0000;
  localparam logic [12:0] V_INIT  = 13'h1800;
  localparam logic [12:0] V_FETCH = 13'h0080;
  localparam logic [12:0] V_LOAD  = 13'h1400;
  localparam logic [12:0] V_DEC   = 13'h0000;
  localparam logic [12:0] V_ACC   = 13'h0020;
  localparam logic [12:0] V_MRD   = 13'h0180;
  localparam logic [12:0] V_MWR   = 13'h0140;
  localparam logic [12:0] V_JMP   = 13'h0200;
  localparam logic [12:0] V_HALT  = 13'h0002;
  localparam logic [12:0] V_TRAP  = 13'h1801;
  localparam logic [12:0] V_HALTI = 13'h0003;

  typedef struct packed {
    logic        rdy;
    logic [4:0]  op;
    logic        fz;
    logic        fc;
    logic [12:0] exp;
  } step_t;

  step_t sb_q[$];

  control_sequencer #(.OPW(5), .ALUW(3), .MEM_TO(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .flag_z(flag_z), .flag_c(flag_c),
    .mem_ready(mem_ready), .ir_ena(ir_ena), .ir_sel(ir_sel), .pc_inc(pc_inc),
    .pc_load(pc_load), .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .acc_we(acc_we), .alu_op(alu_op), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic step_t st(logic rdy, logic [4:0] op, logic fz, logic fc, logic [12:0] e);
    step_t s;
    s.rdy = rdy; s.op = op; s.fz = fz; s.fc = fc; s.exp = e;
    return s;
  endfunction

  function automatic logic [12:0] v_exec(logic [2:0] k);
    return V_ACC | {8'b0, k, 2'b0};
  endfunction

  // Zero-wait FETCH, LOAD, DECODE for one instruction; mem_ready stays high in
  // LOAD/DECODE where it must be ignored.
  task automatic push_fld(input logic [4:0] op, input logic fz, input logic fc);
    sb_q.push_back(st(1'b1, op, fz, fc, V_FETCH));
    sb_q.push_back(st(1'b1, op, fz, fc, V_LOAD));
    sb_q.push_back(st(1'b1, op, fz, fc, V_DEC));
  endtask

  // Hold reset a couple of cycles, release just after a rising edge (DUT in INIT).
  task automatic do_reset();
    rst = 1'b0; mem_ready = 1'b0; opcode = '0; flag_z = 1'b0; flag_c = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    step_t s;
    int i;
    rst = 1'b0; mem_ready = 1'b1; opcode = '0; flag_z = 1'b1; flag_c = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_ZERO) begin
      n_fail++; $display("FAIL reset_hold: got %b need %b", obs, V_ZERO);
    end
    do_reset();
    sb_q.push_back(st(1'b0, 5'd0, 1'b0, 1'b0, V_INIT));
    for (int k = 0; k < 3; k++) sb_q.push_back(st(1'b0, 5'd0, 1'b0, 1'b0, V_FETCH));
    i = 0;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      mem_ready = s.rdy; opcode = s.op; flag_z = s.fz; flag_c = s.fc;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin
        n_fail++; $display("FAIL reset step %0d: got %b need %b", i, obs, s.exp);
      end
      i++;
      @(posedge clk); #1;
    end
    // Mid-transfer reset: mem_rd is up in FETCH, must drop without a clock edge.
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== V_ZERO) begin
      n_fail++; $display("FAIL reset_async: got %b need %b", obs, V_ZERO);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_INIT) begin
      n_fail++; $display("FAIL reset_restart: got %b need %b", obs, V_INIT);
    end
  endtask

  task automatic test_nop();
    step_t s;
    int i;
    do_reset();
    sb_q.push_back(st(1'b1, 5'd0, 1'b0, 1'b0, V_INIT));
    for (int k = 0; k < 3; k++) push_fld(5'd0, 1'b0, 1'b0);
    sb_q.push_back(st(1'b1, 5'd0, 1'b0, 1'b0, V_FETCH));
    i = 0;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      mem_ready = s.rdy; opcode = s.op; flag_z = s.fz; flag_c = s.fc;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin
        n_fail++; $display("FAIL nop step %0d: got %b need %b", i, obs, s.exp);
      end
      i++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    step_t s;
    int i;
    do_reset();
    sb_q.push_back(st(1'b1, 5'd0, 1'b0, 1'b0, V_INIT));
    for (int unsigned k = 0; k < 5; k++) begin
      push_fld(5'(3 + k), 1'b0, 1'b0);
      sb_q.push_back(st(1'b1, 5'(3 + k), 1'b0, 1'b0, v_exec(3'(k + 1))));
    end
    sb_q.push_back(st(1'b1, 5'd0, 1'b0, 1'b0, V_FETCH));
    i = 0;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      mem_ready = s.rdy; opcode = s.op; flag_z = s.fz; flag_c = s.fc;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin
        n_fail++; $display("FAIL alu step %0d: got %b need %b", i, obs, s.exp);
      end
      i++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem();
    step_t s;
    int i;
    do_reset();
    sb_q.push_back(st(1'b1, 5'd0, 1'b0, 1'b0, V_INIT));
    push_fld(5'd1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) sb_q.push_back(st(1'b0, 5'd1, 1'b0, 1'b0, V_MRD));
    sb_q.push_back(st(1'b1, 5'd1, 1'b0, 1'b0, V_MRD | V_ACC));
    push_fld(5'd2, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) sb_q.push_back(st(1'b0, 5'd2, 1'b0, 1'b0, V_MWR));
    sb_q.push_back(st(1'b1, 5'd2, 1'b0, 1'b0, V_MWR));
    // Wait counter restarts per state: 10 waits in FETCH plus 14 in MEMRD never time out.
    for (int k = 0; k < 10; k++) sb_q.push_back(st(1'b0, 5'd1, 1'b0, 1'b0, V_FETCH));
    sb_q.push_back(st(1'b1, 5'd1, 1'b0, 1'b0, V_FETCH));
    sb_q.push_back(st(1'b1, 5'd1, 1'b0, 1'b0, V_LOAD));
    sb_q.push_back(st(1'b1, 5'd1, 1'b0, 1'b0, V_DEC));
    for (int k = 0; k < 14; k++) sb_q.push_back(st(1'b0, 5'd1, 1'b0, 1'b0, V_MRD));
    sb_q.push_back(st(1'b1, 5'd1, 1'b0, 1'b0, V_MRD | V_ACC));
    sb_q.push_back(st(1'b1, 5'd0, 1'b0, 1'b0, V_FETCH));
    i = 0;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      mem_ready = s.rdy; opcode = s.op; flag_z = s.fz; flag_c = s.fc;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin
        n_fail++; $display("FAIL mem step %0d: got %b need %b", i, obs, s.exp);
      end
      i++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    step_t s;
    int i;
    do_reset();
    sb_q.push_back(st(1'b1, 5'd0, 1'b0, 1'b0, V_INIT));
    push_fld(5'd8, 1'b0, 1'b0);  sb_q.push_back(st(1'b1, 5'd8, 1'b0, 1'b0, V_JMP));
    push_fld(5'd9, 1'b1, 1'b0);  sb_q.push_back(st(1'b1, 5'd9, 1'b1, 1'b0, V_JMP));
    push_fld(5'd9, 1'b0, 1'b1);
    push_fld(5'd10, 1'b0, 1'b1); sb_q.push_back(st(1'b1, 5'd10, 1'b0, 1'b1, V_JMP));
    push_fld(5'd10, 1'b1, 1'b0);
    sb_q.push_back(st(1'b1, 5'd0, 1'b0, 1'b0, V_FETCH));
    i = 0;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      mem_ready = s.rdy; opcode = s.op; flag_z = s.fz; flag_c = s.fc;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin
        n_fail++; $display("FAIL branch step %0d: got %b need %b", i, obs, s.exp);
      end
      i++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    step_t s;
    int i;
    do_reset();
    sb_q.push_back(st(1'b0, 5'd0, 1'b0, 1'b0, V_INIT));
    for (int k = 0; k < 15; k++) sb_q.push_back(st(1'b0, 5'd0, 1'b0, 1'b0, V_FETCH));
    for (int k = 0; k < 3; k++)  sb_q.push_back(st(1'b1, 5'd0, 1'b0, 1'b0, V_HALT));
    i = 0;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      mem_ready = s.rdy; opcode = s.op; flag_z = s.fz; flag_c = s.fc;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin
        n_fail++; $display("FAIL timeout_fetch step %0d: got %b need %b", i, obs, s.exp);
      end
      i++;
      @(posedge clk); #1;
    end
    do_reset();
    sb_q.push_back(st(1'b1, 5'd1, 1'b0, 1'b0, V_INIT));
    push_fld(5'd1, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) sb_q.push_back(st(1'b0, 5'd1, 1'b0, 1'b0, V_MRD));
    for (int k = 0; k < 2; k++)  sb_q.push_back(st(1'b1, 5'd1, 1'b0, 1'b0, V_HALT));
    i = 0;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      mem_ready = s.rdy; opcode = s.op; flag_z = s.fz; flag_c = s.fc;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin
        n_fail++; $display("FAIL timeout_memrd step %0d: got %b need %b", i, obs, s.exp);
      end
      i++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_illegal();
    step_t s;
    int i;
    do_reset();
    sb_q.push_back(st(1'b1, 5'd0, 1'b0, 1'b0, V_INIT));
    push_fld(5'd21, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    sb_q.push_back(st(1'b1, 5'd21, 1'b0, 1'b0, V_TRAP));
    for (int k = 0; k < 3; k++) sb_q.push_back(st(1'b1, 5'd0, 1'b0, 1'b0, V_HALTI));
`else
    push_fld(5'd31, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) sb_q.push_back(st(1'b1, 5'd0, 1'b0, 1'b0, V_HALT));
`endif
    i = 0;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      mem_ready = s.rdy; opcode = s.op; flag_z = s.fz; flag_c = s.fc;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin
        n_fail++; $display("FAIL halt_illegal step %0d: got %b need %b", i, obs, s.exp);
      end
      i++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    int i;
    do_reset();
    sb_q.push_back(st(1'b1, 5'd0, 1'b0, 1'b0, V_INIT));
    push_fld(5'd4, 1'b0, 1'b0);  sb_q.push_back(st(1'b1, 5'd4, 1'b0, 1'b0, v_exec(3'd2)));
    push_fld(5'd1, 1'b0, 1'b0);  sb_q.push_back(st(1'b1, 5'd1, 1'b0, 1'b0, V_MRD | V_ACC));
    push_fld(5'd2, 1'b0, 1'b0);  sb_q.push_back(st(1'b1, 5'd2, 1'b0, 1'b0, V_MWR));
    push_fld(5'd10, 1'b0, 1'b1); sb_q.push_back(st(1'b1, 5'd10, 1'b0, 1'b1, V_JMP));
    push_fld(5'd7, 1'b0, 1'b0);  sb_q.push_back(st(1'b1, 5'd7, 1'b0, 1'b0, v_exec(3'd5)));
    push_fld(5'd0, 1'b0, 1'b0);
    push_fld(5'd31, 1'b0, 1'b0); sb_q.push_back(st(1'b1, 5'd0, 1'b0, 1'b0, V_HALT));
    i = 0;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      mem_ready = s.rdy; opcode = s.op; flag_z = s.fz; flag_c = s.fc;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin
        n_fail++; $display("FAIL back_to_back step %0d: got %b need %b", i, obs, s.exp);
      end
      i++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_alu();
    test_mem();
    test_branch();
    test_timeout();
    test_halt_illegal();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
